// File: rtl/i_softmax_ctrl.sv
// Softmax row controller: buffers a row, tracks its signed max, streams buf-max through
// an external exp datapath and accumulates the row sum. Optional macro: SOFTMAX_SUB_SAT_EN.
module i_softmax_ctrl #(
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         cfg_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  output logic [31:0]        exp_q_in,
  input  logic [31:0]        exp_q_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic               sum_valid,
  output logic [39:0]        sum_out
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = (CW > 7) ? CW : 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_len;
  logic [CW-1:0]      r_wr_idx;
  logic [CW-1:0]      r_rd_idx;
  logic signed [31:0] r_max;
  logic [39:0]        r_sum;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic               r_out_last;
  logic               r_sum_valid;
  logic signed [31:0] r_buf [MAX_LEN];

  logic [LW-1:0]      w_cfg_ext;
  logic [LW-1:0]      w_len_clip;
  logic [CW-1:0]      w_len_new;
  logic [CW-1:0]      w_len_m1;
  logic signed [31:0] w_buf_rd;
  logic [31:0]        w_diff;
  logic               w_in_fire;
  logic               w_out_load;
  logic               w_out_fire;

  // Difference buf - max; the sign of the operands decides whether overflow is possible.
  function automatic logic [31:0] sub_diff(input logic [31:0] a, input logic [31:0] m);
    logic [31:0] d;
    d = a - m;
`ifdef SOFTMAX_SUB_SAT_EN
    if ((a[31] != m[31]) && (d[31] != a[31])) begin
      d = 32'h8000_0000;
    end else begin
      d = d;
    end
`endif
    return d;
  endfunction

  // Row length clip, datapath operand and handshake qualifiers.
  always_comb begin
    w_cfg_ext  = LW'(cfg_len);
    w_len_clip = (w_cfg_ext > LW'(MAX_LEN)) ? LW'(MAX_LEN) : w_cfg_ext;
    w_len_new  = CW'(w_len_clip);
    w_len_m1   = r_len - CW'(1);
    w_buf_rd   = r_buf[r_rd_idx[IW-1:0]];
    w_diff     = sub_diff(w_buf_rd, r_max);
    w_in_fire  = (r_state == S_LOAD) && in_valid;
    w_out_load = (r_state == S_EXP) && (r_rd_idx < r_len) && (!r_out_valid || out_ready);
    w_out_fire = r_out_valid && out_ready;
    if (r_state == S_EXP) begin
      exp_q_in = w_diff;
    end else begin
      exp_q_in = 32'd0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sum_valid = r_sum_valid;
  assign sum_out   = r_sum;

  // Row buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_wr_idx[IW-1:0]] <= in_data;
    end
  end

  // Control FSM with output register and sum accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_max       <= 32'sh8000_0000;
      r_sum       <= 40'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_last  <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sum_valid <= 1'b0;
          if (start) begin
            r_len      <= w_len_new;
            r_max      <= 32'sh8000_0000;
            r_sum      <= 40'd0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_out_last <= 1'b0;
            if (w_len_new == '0) begin
              r_state     <= S_DONE;
              r_sum_valid <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_in_fire) begin
            if (in_data > r_max) begin
              r_max <= in_data;
            end
            r_wr_idx <= r_wr_idx + CW'(1);
            if (r_wr_idx == w_len_m1) begin
              r_state <= S_EXP;
            end
          end
        end
        S_EXP: begin
          if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= exp_q_out;
            r_out_last  <= (r_rd_idx == w_len_m1);
            r_rd_idx    <= r_rd_idx + CW'(1);
            r_sum       <= r_sum + {8'd0, exp_q_out};
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
          // The last element leaves only via a transfer; no new load can coincide with it.
          if (w_out_fire && r_out_last) begin
            r_state     <= S_DONE;
            r_sum_valid <= 1'b1;
          end
        end
        S_DONE: begin
          r_sum_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_softmax_ctrl.sv
// Scoreboard bench for i_softmax_ctrl; the exp datapath is modelled as exp_q_out = -exp_q_in.
module tb_i_softmax_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [6:0]         cfg_len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic [31:0]        exp_q_in;
  logic [31:0]        exp_q_out;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               out_last;
  logic               sum_valid;
  logic [39:0]        sum_out;

  always #5 clk = ~clk;

  i_softmax_ctrl #(.MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .exp_q_in(exp_q_in), .exp_q_out(exp_q_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sum_valid(sum_valid), .sum_out(sum_out)
  );

  assign exp_q_out = -exp_q_in;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [31:0] row_q [$];
  logic [32:0]        sb_q  [$];
  logic [39:0]        exp_sum;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] model_diff(input logic signed [31:0] a, input logic signed [31:0] m);
    longint full;
    full = longint'(a) - longint'(m);
`ifdef SOFTMAX_SUB_SAT_EN
    if (full < -64'sd2147483648) return 32'h8000_0000;
`endif
    return full[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},   busy, 64'd0);
    check_eq({tag, "_inrdy"},  in_ready, 64'd0);
    check_eq({tag, "_ovalid"}, out_valid, 64'd0);
    check_eq({tag, "_olast"},  out_last, 64'd0);
    check_eq({tag, "_svalid"}, sum_valid, 64'd0);
    check_eq({tag, "_odata"},  out_data, 64'd0);
    check_eq({tag, "_sum"},    sum_out, 64'd0);
    check_eq({tag, "_qin"},    exp_q_in, 64'd0);
  endtask

  // Runs one row from row_q; stall_mode 1 drives out_ready 1,0,0,1,0,0,...
  task automatic do_row(input int cfg, input int stall_mode);
    int n, k, got, cyc, pidx;
    logic signed [31:0] mx;
    logic [31:0] d, e, first_q, held_data;
    logic held, held_last;
    logic [32:0] sbe;
    n  = (cfg > 64) ? 64 : cfg;
    mx = 32'sh8000_0000;
    for (int i = 0; i < n; i++) if (row_q[i] > mx) mx = row_q[i];
    exp_sum = 40'd0;
    first_q = 32'd0;
    for (int i = 0; i < n; i++) begin
      d = model_diff(row_q[i], mx);
      if (i == 0) first_q = d;
      e = -d;
      sb_q.push_back({(i == n - 1), e});
      exp_sum = exp_sum + {8'd0, e};
    end
    start = 1'b1; cfg_len = 7'(cfg);
    tick();
    start = 1'b0;
    check_eq("busy_start", busy, 64'd1);
    if (n == 0) begin
      check_eq("empty_svalid", sum_valid, 64'd1);
      check_eq("empty_sum", sum_out, 64'd0);
      check_eq("empty_ovalid", out_valid, 64'd0);
      tick();
      check_eq("empty_busy_end", busy, 64'd0);
      check_eq("empty_ovalid2", out_valid, 64'd0);
      return;
    end
    k = 0; cyc = 0;
    while (k < row_q.size() && cyc < 200 && in_ready) begin
      in_valid = 1'b1; in_data = row_q[k];
      tick();
      k++; cyc++;
    end
    in_valid = 1'b0;
    check_eq("accepted", k, n);
    check_eq("ready_exp", in_ready, 64'd0);
    check_eq("early_ovalid", out_valid, 64'd0);
    check_eq("first_q", exp_q_in, first_q);
    tick();
    check_eq("first_lat", out_valid, 64'd1);
    got = 0; cyc = 0; held = 1'b0; pidx = 0;
    held_data = 32'd0; held_last = 1'b0;
    while (got < n && cyc < 1000) begin
      if (held) begin
        check_eq("stall_valid", out_valid, 64'd1);
        check_eq("stall_data", out_data, held_data);
        check_eq("stall_last", out_last, held_last);
      end
      if (out_valid) begin
        out_ready = (stall_mode == 0) || (pidx % 3 == 0);
        pidx++;
        if (out_ready) begin
          sbe = sb_q.pop_front();
          check_eq("out_data", out_data, sbe[31:0]);
          check_eq("out_last", out_last, sbe[32]);
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1; held_data = out_data; held_last = out_last;
        end
      end
      tick();
      cyc++;
    end
    check_eq("out_count", got, n);
    check_eq("done_svalid", sum_valid, 64'd1);
    check_eq("done_sum", sum_out, exp_sum);
    check_eq("done_ovalid", out_valid, 64'd0);
    out_ready = 1'b1;
    tick();
    check_eq("idle_busy", busy, 64'd0);
    check_eq("idle_svalid", sum_valid, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = 7'd0;
    in_valid = 1'b0; in_data = 32'sd0; out_ready = 1'b1;
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    row_q = '{32'sd3, -32'sd1, 32'sd7, 32'sd0};
    do_row(4, 0);
    check_eq("basic_sum_const", sum_out, 64'd19);

    row_q = '{32'sd10, -32'sd20, 32'sd5};
    do_row(3, 1);

    row_q.delete();
    do_row(0, 0);

    row_q.delete();
    for (int i = 0; i < 100; i++) row_q.push_back(int'($urandom_range(0, 2000)) - 1000);
    do_row(100, 0);

    row_q = '{32'sh8000_0000, 32'sh7FFF_FFFF};
    do_row(2, 0);

    // Reset in the middle of EXP while an output is being held.
    start = 1'b1; cfg_len = 7'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = i;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_eq("pre_rst_ovalid", out_valid, 64'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check_eq("post_rst_busy", busy, 64'd0);
    row_q = '{32'sd100, -32'sd5};
    do_row(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i_softmax_ctrl.md
I_SOFTMAX_CTRL -- requirements
Module: i_softmax_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, giving the maximum row length and the buffer depth.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: starts a row when idle.
REQ-005 SHALL have port cfg_len, input, 7 bits: row length, sampled on the accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 32, signed): the input element stream.
REQ-008 SHALL have port exp_q_in, output, 32 bits: operand driven to the external combinational I_EXP datapath.
REQ-009 SHALL have port exp_q_out, input, 32 bits: I_EXP result, treated as unsigned, same cycle as exp_q_in.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32), out_last (output, 1): the exp result stream.
REQ-011 SHALL have ports sum_valid (output, 1) and sum_out (output, 40): row sum, valid for one cycle.

Function
REQ-012 SHALL implement states IDLE, LOAD, EXP, DONE.
REQ-013 In IDLE, start=1 SHALL latch len=min(cfg_len,MAX_LEN), clear max to 32'h8000_0000 and clear the sum.
REQ-014 From IDLE on start, len=0 SHALL go to DONE and len>0 SHALL go to LOAD.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready transfer SHALL write buf[idx] and update max as a signed max.
REQ-017 The transfer of element len-1 SHALL move LOAD to EXP.
REQ-018 In EXP, exp_q_in SHALL equal buf[rd_idx] minus max, 32-bit signed.
REQ-019 The output register SHALL load exp_q_out when it is empty or out_ready=1.
REQ-020 On that load, out_last SHALL be set to (rd_idx==len-1), rd_idx SHALL advance, and exp_q_out zero-extended SHALL be added to sum.
REQ-021 Throughput SHALL be one element per cycle while out_ready=1.
REQ-022 The first out_valid SHALL appear in the cycle after entering EXP.
REQ-023 out_valid, out_data and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-024 The out_last transfer SHALL move EXP to DONE.
REQ-025 DONE SHALL last exactly one cycle with sum_valid=1 and sum_out = the row sum, then return to IDLE.
REQ-026 sum_out SHALL be 40 bits wide so that it never overflows for MAX_LEN ≤ 256.
REQ-027 in_ready SHALL be 0 outside LOAD.
REQ-028 exp_q_in SHALL be 0 outside EXP.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, clear the indices and the sum, and set max to 32'h8000_0000, from any state including mid-row.
REQ-030 During and after reset, busy, in_ready, out_valid, out_last, sum_valid, out_data, sum_out and exp_q_in SHALL all be 0.
REQ-031 Buffer contents SHALL not require reset.

Configuration
REQ-032 SHALL support macro SOFTMAX_SUB_SAT_EN.
REQ-033 When SOFTMAX_SUB_SAT_EN is defined, a buf-max difference overflowing 32-bit signed SHALL saturate to 32'h8000_0000.
REQ-034 When SOFTMAX_SUB_SAT_EN is undefined, the difference SHALL wrap modulo 2^32.

Verification (bench drives exp_q_out = -exp_q_in)
REQ-035 Bench SHALL run start, cfg_len=4, inputs {3,-1,7,0}, out_ready=1 -> out_data {4,8,0,7}, out_last on the 4th, sum_out=19, sum_valid one cycle after the 4th output.
REQ-036 Bench SHALL run len=3 with out_ready toggled 1,0,0,1,... -> no data lost or duplicated and out_data stable while stalled.
REQ-037 Bench SHALL run cfg_len=0 -> no out_valid, sum_valid=1 with sum_out=0 one cycle after start, then busy=0.
REQ-038 Bench SHALL run cfg_len=100 with MAX_LEN=64 -> exactly 64 inputs accepted and 64 outputs produced.
REQ-039 Bench SHALL run inputs {32'h8000_0000, 32'h7FFF_FFFF} -> first exp_q_in equals 32'h8000_0000 with SOFTMAX_SUB_SAT_EN and 32'h0000_0001 without it.
REQ-040 Bench SHALL assert rst_n=0 mid-EXP -> next cycle all outputs 0 and state IDLE, and a new row of len=2 then completes correctly.
